// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: glyph lit masks,
// segment bit positions, the idle anode pattern and the sampled scan word.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [3:0] AN_OFF = 4'hF;

    // Lit masks in {g,f,e,d,c,b,a} order, indexed by the hex value they show.
    localparam logic [15:0][6:0] GLYPH_LIT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } scan_t;

    localparam scan_t SCAN_IDLE = '{an: AN_OFF, seg: 8'hFF};

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph lookup: maps a 7-bit active-high lit mask to its hex
// value, flagging whether it is a legal glyph or fully dark.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] lit_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] value_o
);

    always_comb begin
        legal_o = 1'b0;
        value_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (lit_i == GLYPH_LIT[i]) begin
                legal_o = 1'b1;
                value_o = 4'(i);
            end
        end
    end

    assign blank_o = (lit_i == 7'h00);

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the four hex digits, decimal points and blank flags from a
// multiplexed active-low seven-segment scan, capturing only stable dwells.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned CNT_W         = 10
) (
    input  logic        Clk100M,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic [3:0]  glyph_err,
    output logic        frame_valid,
    output logic        an_err
);

    // Holding at STABLE_CYCLES-1 is enough: the strobe fires only on the step before it.
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_PRE = CNT_W'(STABLE_CYCLES - 2);

    scan_t            s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       dp_q, dp_d;
    logic [3:0]       blank_q, blank_d;
    logic [3:0]       glyph_err_q, glyph_err_d;
    logic [3:0]       seen_q, seen_d;
    logic             frame_valid_q, frame_valid_d;
    logic             an_err_q, an_err_d;

    logic             stable, strobe, capture, an_multi;
    logic [3:0]       an_low;
    logic [6:0]       lit;
    logic             g_legal, g_blank;
    logic [3:0]       g_value;

    assign lit = ~s2_q.seg[SEG_G:SEG_A];

    seg_glyph_decode u_glyph (
        .lit_i   (lit),
        .legal_o (g_legal),
        .blank_o (g_blank),
        .value_o (g_value)
    );

    always_comb begin
        s1_d    = '{an: an, seg: seg};
        s2_d    = s1_q;
        prev_d  = s2_q;
        stable  = (s2_q == prev_q);
        dwell_d = dwell_q;
        if (!stable) begin
            dwell_d = '0;
        end else if (dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + CNT_W'(1);
        end
        strobe   = stable && (dwell_q == DWELL_PRE);
        an_low   = ~s2_q.an;
        capture  = strobe && is_one_hot(an_low);
        an_multi = (an_low != 4'h0) && !is_one_hot(an_low);
    end

    always_comb begin
        digits_d      = digits_q;
        dp_d          = dp_q;
        blank_d       = blank_q;
        glyph_err_d   = glyph_err_q;
        seen_d        = seen_q;
        frame_valid_d = (seen_q == 4'hF);
        an_err_d      = strobe && an_multi;
        if (frame_valid_d) begin
            seen_d = 4'h0;
        end
        for (int i = 0; i < 4; i++) begin
            if (capture && an_low[i]) begin
                seen_d[i] = 1'b1;
                dp_d[i]   = ~s2_q.seg[SEG_DP];
                if (g_legal) begin
                    digits_d[4*i +: 4] = g_value;
                    blank_d[i]         = 1'b0;
                    glyph_err_d[i]     = 1'b0;
                end else if (g_blank) begin
                    blank_d[i]     = 1'b1;
                    glyph_err_d[i] = 1'b0;
                end else begin
                    glyph_err_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk100M or posedge rst) begin
        if (rst) begin
            s1_q          <= SCAN_IDLE;
            s2_q          <= SCAN_IDLE;
            prev_q        <= SCAN_IDLE;
            dwell_q       <= '0;
            digits_q      <= 16'h0000;
            dp_q          <= 4'h0;
            blank_q       <= 4'hF;
            glyph_err_q   <= 4'h0;
            seen_q        <= 4'h0;
            frame_valid_q <= 1'b0;
            an_err_q      <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            prev_q        <= prev_d;
            dwell_q       <= dwell_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            blank_q       <= blank_d;
            glyph_err_q   <= glyph_err_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            an_err_q      <= an_err_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign blank       = blank_q;
    assign glyph_err   = glyph_err_q;
    assign frame_valid = frame_valid_q;
    assign an_err      = an_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus random
// scans, checked against a dwell/glyph reference model.
module tb_seg_scan_decoder;

    localparam int unsigned S    = 8;
    localparam logic [11:0] IDLE = 12'hFFF;

    logic        Clk100M = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  dp, blank, glyph_err;
    logic        frame_valid, an_err;

    seg_scan_decoder #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
        .Clk100M     (Clk100M),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .glyph_err   (glyph_err),
        .frame_valid (frame_valid),
        .an_err      (an_err)
    );

    always #5 Clk100M = ~Clk100M;

    int errors = 0;
    int checks = 0;
    int fv_seen = 0;
    int ae_seen = 0;

    // Counts high cycles, so a stretched pulse shows up as an extra count.
    always @(posedge Clk100M) begin
        #2;
        if (frame_valid === 1'b1) fv_seen++;
        if (an_err === 1'b1) ae_seen++;
    end

    // Reference model
    logic [6:0]  lit_tab [16];
    logic [3:0]  m_digit [4];
    logic [3:0]  m_dp, m_blank, m_gerr, m_seen;
    int          exp_fv = 0;
    int          exp_ae = 0;
    logic [11:0] m_last;
    int          m_run;
    bit          m_done;

    function automatic logic [6:0] mask_of(input string s);
        logic [6:0] m = '0;
        for (int k = 0; k < s.len(); k++) m[int'(s[k]) - 97] = 1'b1;
        return m;
    endfunction

    function automatic void init_tables();
        lit_tab[0]  = mask_of("abcdef");
        lit_tab[1]  = mask_of("bc");
        lit_tab[2]  = mask_of("abdeg");
        lit_tab[3]  = mask_of("abcdg");
        lit_tab[4]  = mask_of("bcfg");
        lit_tab[5]  = mask_of("acdfg");
        lit_tab[6]  = mask_of("acdefg");
        lit_tab[7]  = mask_of("abc");
        lit_tab[8]  = mask_of("abcdefg");
        lit_tab[9]  = mask_of("abcdfg");
        lit_tab[10] = mask_of("abcefg");
        lit_tab[11] = mask_of("cdefg");
        lit_tab[12] = mask_of("adef");
        lit_tab[13] = mask_of("bcdeg");
        lit_tab[14] = mask_of("adefg");
        lit_tab[15] = mask_of("aefg");
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
        m_dp = 4'h0; m_blank = 4'hF; m_gerr = 4'h0; m_seen = 4'h0;
        m_last = IDLE; m_run = S; m_done = 1'b1;
    endfunction

    function automatic void model_capture(input logic [3:0] a, input logic [7:0] s);
        int lows = 0;
        int idx = 0;
        int val = -1;
        logic [6:0] lit;
        for (int i = 0; i < 4; i++) if (!a[i]) begin lows++; idx = i; end
        if (lows == 0) return;
        if (lows > 1) begin exp_ae++; return; end
        m_seen[idx] = 1'b1;
        m_dp[idx] = ~s[7];
        lit = ~s[6:0];
        for (int v = 0; v < 16; v++) if (lit_tab[v] == lit) val = v;
        if (val >= 0) begin
            m_digit[idx] = 4'(val); m_blank[idx] = 1'b0; m_gerr[idx] = 1'b0;
        end else if (lit == 7'h00) begin
            m_blank[idx] = 1'b1; m_gerr[idx] = 1'b0;
        end else begin
            m_gerr[idx] = 1'b1;
        end
        if (m_seen == 4'hF) begin exp_fv++; m_seen = 4'h0; end
    endfunction

    function automatic logic [27:0] model_outputs();
        return {m_digit[3], m_digit[2], m_digit[1], m_digit[0], m_dp, m_blank, m_gerr};
    endfunction

    function automatic logic [7:0] glyph_seg(input int v, input bit dp_on);
        return {~dp_on, ~lit_tab[v]};
    endfunction

    // Holds {a,s} for n cycles; the model captures once per run of >= S identical cycles.
    task automatic present(input logic [3:0] a, input logic [7:0] s, input int n);
        an = a;
        seg = s;
        repeat (n) @(negedge Clk100M);
        if ({a, s} == m_last) m_run += n;
        else begin m_last = {a, s}; m_run = n; m_done = 1'b0; end
        if (!m_done && m_run >= S) begin m_done = 1'b1; model_capture(a, s); end
    endtask

    task automatic settle();
        present(4'hF, 8'hFF, 20);
    endtask

    task automatic test_reset();
        checks++;
        if ({digits, dp, blank, glyph_err, frame_valid, an_err} !== {16'h0, 4'h0, 4'hF, 4'h0, 2'b00}) begin
            errors++;
            $display("FAIL reset_values: got %h required %h",
                     {digits, dp, blank, glyph_err, frame_valid, an_err},
                     {16'h0, 4'h0, 4'hF, 4'h0, 2'b00});
        end
        rst = 1'b0;
        settle();
        checks++;
        if ({digits, dp, blank, glyph_err} !== model_outputs()) begin
            errors++;
            $display("FAIL reset_idle: got %h required %h", {digits, dp, blank, glyph_err}, model_outputs());
        end
        checks++;
        if (fv_seen !== 0 || ae_seen !== 0) begin
            errors++;
            $display("FAIL reset_pulses: got fv=%0d ae=%0d required 0 0", fv_seen, ae_seen);
        end
    endtask

    task automatic test_scan();
        int fv0 = fv_seen;
        present(4'hE, 8'hC0, 20);
        present(4'hD, 8'hF9, 20);
        present(4'hB, 8'hA4, 20);
        present(4'h7, 8'hB0, 20);
        settle();
        checks++;
        if ({digits, blank, dp} !== {16'h3210, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL scan_digits: got %h required %h", {digits, blank, dp}, {16'h3210, 4'h0, 4'h0});
        end
        checks++;
        if (fv_seen - fv0 !== 1) begin
            errors++;
            $display("FAIL scan_frame: got %0d pulses required 1", fv_seen - fv0);
        end
        checks++;
        if (fv_seen !== exp_fv || ae_seen !== exp_ae) begin
            errors++;
            $display("FAIL scan_model_pulses: got fv=%0d ae=%0d required %0d %0d", fv_seen, ae_seen, exp_fv, exp_ae);
        end
    endtask

    task automatic test_dp();
        present(4'hE, 8'h40, 20);
        settle();
        checks++;
        if ({digits[3:0], dp[0]} !== 5'b0000_1) begin
            errors++;
            $display("FAIL dp_capture: got digit=%h dp=%b required 0 1", digits[3:0], dp[0]);
        end
        present(4'hE, 8'hF9, 5);
        settle();
        checks++;
        if ({digits[3:0], dp[0]} !== 5'b0000_1) begin
            errors++;
            $display("FAIL short_dwell: got digit=%h dp=%b required 0 1", digits[3:0], dp[0]);
        end
    endtask

    task automatic test_an_err();
        int ae0 = ae_seen;
        int fv0 = fv_seen;
        present(4'hC, 8'hC0, 20);
        checks++;
        if (ae_seen - ae0 !== 1) begin
            errors++;
            $display("FAIL an_err_pulse: got %0d pulses required 1", ae_seen - ae0);
        end
        present(4'hF, 8'hC0, 20);
        checks++;
        if (ae_seen - ae0 !== 1 || digits !== 16'h3210) begin
            errors++;
            $display("FAIL an_off: got ae=%0d digits=%h required 1 3210", ae_seen - ae0, digits);
        end
        present(4'hB, 8'h88, 20);
        present(4'h7, 8'h86, 20);
        settle();
        checks++;
        if (fv_seen - fv0 !== 0) begin
            errors++;
            $display("FAIL an_err_seen: got %0d frames required 0", fv_seen - fv0);
        end
        present(4'hD, 8'h92, 20);
        settle();
        checks++;
        if (fv_seen - fv0 !== 1 || digits !== 16'hEA50) begin
            errors++;
            $display("FAIL an_err_frame: got frames=%0d digits=%h required 1 EA50", fv_seen - fv0, digits);
        end
    endtask

    task automatic test_glyph();
        present(4'hB, 8'hFF, 20);
        settle();
        checks++;
        if ({blank[2], glyph_err[2], digits[11:8]} !== {1'b1, 1'b0, 4'hA}) begin
            errors++;
            $display("FAIL glyph_blank: got %b required %b", {blank[2], glyph_err[2], digits[11:8]}, {1'b1, 1'b0, 4'hA});
        end
        present(4'hB, 8'hF6, 20);
        settle();
        checks++;
        if ({blank[2], glyph_err[2], digits[11:8]} !== {1'b1, 1'b1, 4'hA}) begin
            errors++;
            $display("FAIL glyph_illegal: got %b required %b", {blank[2], glyph_err[2], digits[11:8]}, {1'b1, 1'b1, 4'hA});
        end
        checks++;
        if ({digits, dp, blank, glyph_err} !== model_outputs()) begin
            errors++;
            $display("FAIL glyph_model: got %h required %h", {digits, dp, blank, glyph_err}, model_outputs());
        end
    endtask

    task automatic test_fast_toggle();
        for (int k = 0; k < 50; k++) present(4'hE, (k % 2 == 0) ? 8'hF9 : 8'hA4, 4);
        checks++;
        if ({digits, dp, blank, glyph_err} !== model_outputs()) begin
            errors++;
            $display("FAIL toggle_outputs: got %h required %h", {digits, dp, blank, glyph_err}, model_outputs());
        end
        settle();
        checks++;
        if (fv_seen !== exp_fv || ae_seen !== exp_ae || digits[3:0] !== 4'h0) begin
            errors++;
            $display("FAIL toggle_pulses: got fv=%0d ae=%0d d0=%h required %0d %0d 0",
                     fv_seen, ae_seen, digits[3:0], exp_fv, exp_ae);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [3:0] one;
        logic [7:0] s;
        int n;
        int r;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            one = 4'b0001;
            if (r < 7) a = ~(one << $urandom_range(0, 3));
            else if (r == 7) a = 4'hF;
            else begin
                do a = 4'($urandom); while ($countones(~a) < 2);
            end
            r = $urandom_range(0, 9);
            if (r < 7) s = glyph_seg($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            else if (r == 7) s = {1'($urandom_range(0, 1)), 7'h7F};
            else s = 8'($urandom);
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, S - 2) : 20;
            present(a, s, n);
            if (it % 10 == 9) begin
                settle();
                checks++;
                if ({digits, dp, blank, glyph_err} !== model_outputs()) begin
                    errors++;
                    $display("FAIL random_outputs: got %h required %h", {digits, dp, blank, glyph_err}, model_outputs());
                end
                checks++;
                if (fv_seen !== exp_fv || ae_seen !== exp_ae) begin
                    errors++;
                    $display("FAIL random_pulses: got fv=%0d ae=%0d required %0d %0d", fv_seen, ae_seen, exp_fv, exp_ae);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int fv0;
        present(4'hE, 8'hF9, 20);
        present(4'hD, 8'hA4, 20);
        present(4'hB, 8'hB0, 4);
        rst = 1'b1;
        an = 4'hF;
        seg = 8'hFF;
        repeat (3) @(negedge Clk100M);
        checks++;
        if ({digits, dp, blank, glyph_err, frame_valid, an_err} !== {16'h0, 4'h0, 4'hF, 4'h0, 2'b00}) begin
            errors++;
            $display("FAIL mid_reset_values: got %h required %h",
                     {digits, dp, blank, glyph_err, frame_valid, an_err}, {16'h0, 4'h0, 4'hF, 4'h0, 2'b00});
        end
        rst = 1'b0;
        model_reset();
        fv0 = fv_seen;
        present(4'hB, 8'hB0, 20);
        present(4'h7, 8'h99, 20);
        settle();
        checks++;
        if (fv_seen - fv0 !== 0 || digits !== 16'h4300) begin
            errors++;
            $display("FAIL mid_reset_seen: got frames=%0d digits=%h required 0 4300", fv_seen - fv0, digits);
        end
        checks++;
        if ({digits, dp, blank, glyph_err} !== model_outputs() || fv_seen !== exp_fv) begin
            errors++;
            $display("FAIL mid_reset_model: got %h fv=%0d required %h %0d",
                     {digits, dp, blank, glyph_err}, fv_seen, model_outputs(), exp_fv);
        end
    endtask

    task automatic test_back_to_back();
        int fv0 = fv_seen;
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 4; d++) begin
                logic [3:0] one = 4'b0001;
                present(~(one << d), glyph_seg($urandom_range(0, 15), 1'($urandom_range(0, 1))), 20);
            end
        end
        settle();
        checks++;
        if (fv_seen - fv0 !== 2 || fv_seen !== exp_fv) begin
            errors++;
            $display("FAIL back_to_back_frames: got %0d required 2 (model %0d)", fv_seen - fv0, exp_fv - fv0);
        end
        checks++;
        if ({digits, dp, blank, glyph_err} !== model_outputs()) begin
            errors++;
            $display("FAIL back_to_back_outputs: got %h required %h", {digits, dp, blank, glyph_err}, model_outputs());
        end
    endtask

    initial begin
        rst = 1'b1;
        an = 4'hF;
        seg = 8'hFF;
        init_tables();
        model_reset();
        repeat (3) @(negedge Clk100M);
        test_reset();
        test_scan();
        test_dp();
        test_an_err();
        test_glyph();
        test_fast_toggle();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
